regfile_wb_ctrl: RTL and testbench

- Write-back controller for the 32x32 integer register file (2 read ports, 1 write port, writes on negedge clk_i, x0 hard-wired to zero).
- Arbitrates the single write port round-robin among NSRC write-back sources with valid/ready handshakes.
- Keeps a busy-register scoreboard that stalls issue on RAW and WAW hazards against pending writes.
- Sits between issue/decode, the execution units and the register file.

---
 rtl/regfile_wb_ctrl.sv | 117 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: round-robin arbiter for the register-file write port plus a
// busy-register scoreboard that stalls issue on RAW/WAW hazards against pending writes.
module regfile_wb_ctrl #(
  parameter int NSRC = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  input  logic [AW-1:0]      issue_rs1_i,
  input  logic [AW-1:0]      issue_rs2_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic               issue_rd_we_i,
  output logic               issue_stall_o,
  output logic               issue_fire_o,
  input  logic               flush_i,
  input  logic [NSRC-1:0]    wb_valid_i,
  input  logic [NSRC*AW-1:0] wb_rd_i,
  input  logic [NSRC*DW-1:0] wb_data_i,
  output logic [NSRC-1:0]    wb_ready_o,
  output logic               reg_write_en_o,
  output logic [AW-1:0]      rd_ptr_o,
  output logic [DW-1:0]      rd_o,
  output logic [31:0]        busy_o
);

  localparam int PW = $clog2(NSRC);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_q, rd_d;

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic [AW-1:0] gnt_rd;
  logic [DW-1:0] gnt_data;

  // Rotating priority search starting at rr_ptr; no grants while reset is held.
  always_comb begin
    int cand;
    logic [PW-1:0] cand_idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NSRC;
      cand_idx = PW'(cand);
      if (!gnt_vld && rst_ni && wb_valid_i[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    wb_ready_o = '0;
    if (gnt_vld) begin
      wb_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign gnt_rd   = wb_rd_i[gnt_idx*AW +: AW];
  assign gnt_data = wb_data_i[gnt_idx*DW +: DW];

  assign issue_stall_o = issue_valid_i &&
                         (busy_q[issue_rs1_i] || busy_q[issue_rs2_i] ||
                          (issue_rd_we_i && busy_q[issue_rd_i]));
  assign issue_fire_o  = issue_valid_i && !issue_stall_o;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    rd_ptr_d = rd_ptr_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == PW'(NSRC - 1)) ? '0 : gnt_idx + PW'(1);
      we_d     = (gnt_rd != '0);
      rd_ptr_d = gnt_rd;
      rd_d     = gnt_data;
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (gnt_vld && gnt_rd != '0) begin
      busy_d[gnt_rd] = 1'b0;
    end
    // Applied last so a new producer wins over a retiring one on the same register.
    if (issue_fire_o && issue_rd_we_i && issue_rd_i != '0) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      rd_ptr_q <= '0;
      rd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      rd_ptr_q <= rd_ptr_d;
      rd_q     <= rd_d;
    end
  end

  assign reg_write_en_o = we_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign rd_o           = rd_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl; expected write-port transfers are queued when a
// grant is expected and popped one cycle later against the registered write port.
module tb_regfile_wb_ctrl;
  localparam int NSRC = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               issue_valid_i;
  logic [AW-1:0]      issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic               issue_rd_we_i;
  logic               issue_stall_o, issue_fire_o;
  logic               flush_i;
  logic [NSRC-1:0]    wb_valid_i;
  logic [NSRC*AW-1:0] wb_rd_i;
  logic [NSRC*DW-1:0] wb_data_i;
  logic [NSRC-1:0]    wb_ready_o;
  logic               reg_write_en_o;
  logic [AW-1:0]      rd_ptr_o;
  logic [DW-1:0]      rd_o;
  logic [31:0]        busy_o;

  typedef struct {
    logic          en;
    logic [AW-1:0] ptr;
    logic [DW-1:0] dat;
    logic          chk_pd;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  regfile_wb_ctrl #(.NSRC(NSRC), .AW(AW), .DW(DW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_rd_i     (issue_rd_i),
    .issue_rd_we_i  (issue_rd_we_i),
    .issue_stall_o  (issue_stall_o),
    .issue_fire_o   (issue_fire_o),
    .flush_i        (flush_i),
    .wb_valid_i     (wb_valid_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .wb_ready_o     (wb_ready_o),
    .reg_write_en_o (reg_write_en_o),
    .rd_ptr_o       (rd_ptr_o),
    .rd_o           (rd_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic we);
    issue_valid_i = v;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
    issue_rd_i    = rd;
    issue_rd_we_i = we;
  endtask

  task automatic push(input logic en, input logic [AW-1:0] ptr, input logic [DW-1:0] dat,
                      input logic chk_pd);
    wr_t w;
    w.en = en; w.ptr = ptr; w.dat = dat; w.chk_pd = chk_pd;
    exp_q.push_back(w);
  endtask

  task automatic pop_chk(input string tag);
    wr_t w;
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk({tag, "_we"}, 64'(reg_write_en_o), 64'(w.en));
      if (w.chk_pd) begin
        chk({tag, "_ptr"}, 64'(rd_ptr_o), 64'(w.ptr));
        chk({tag, "_dat"}, 64'(rd_o), 64'(w.dat));
      end
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    wb_valid_i = '0;
    wb_rd_i    = '0;
    wb_data_i  = '0;
    issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_we", 64'(reg_write_en_o), 64'd0);
    chk("rst_ready", 64'(wb_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(issue_stall_o), 64'd0);
    chk("rst_ptr", 64'(rd_ptr_o), 64'd0);
    chk("rst_dat", 64'(rd_o), 64'd0);
    issue_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // RAW: issue rd=5, then a consumer of r5 stalls until source 1 writes it back
    issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    @(negedge clk_i);
    chk("raw_a_stall", 64'(issue_stall_o), 64'd0);
    chk("raw_a_fire", 64'(issue_fire_o), 64'd1);
    @(posedge clk_i); #1;
    chk("raw_busy5", 64'(busy_o), 64'(32'h1 << 5));
    issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
    wb_valid_i = 3'b010;
    wb_rd_i[1*AW +: AW]   = 5'd5;
    wb_data_i[1*DW +: DW] = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("raw_b_stall", 64'(issue_stall_o), 64'd1);
    chk("raw_b_fire", 64'(issue_fire_o), 64'd0);
    chk("raw_b_ready", 64'(wb_ready_o), 64'b010);
    push(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    @(posedge clk_i); #1;
    pop_chk("raw_wr");
    chk("raw_busy_clr", 64'(busy_o), 64'd0);
    chk("raw_unstall", 64'(issue_stall_o), 64'd0);
    issue_valid_i = 1'b0;
    wb_valid_i    = '0;
    @(posedge clk_i); #1;
    chk("idle_we", 64'(reg_write_en_o), 64'd0);
    chk("idle_ptr_hold", 64'(rd_ptr_o), 64'd5);
    chk("idle_dat_hold", 64'(rd_o), 64'hDEADBEEF);

    // x0 write: handshake completes, no register-file write, busy untouched
    issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    chk("x0_pre_busy", 64'(busy_o), 64'(32'h1 << 9));
    wb_valid_i = 3'b001;
    wb_rd_i[0*AW +: AW]   = 5'd0;
    wb_data_i[0*DW +: DW] = 32'h1234;
    @(negedge clk_i);
    chk("x0_ready", 64'(wb_ready_o), 64'b001);
    push(1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk_i); #1;
    wb_valid_i = '0;
    pop_chk("x0_wr");
    chk("x0_busy", 64'(busy_o), 64'(32'h1 << 9));

    // Same-register set and clear in one cycle: set wins
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    wb_valid_i = 3'b100;
    wb_rd_i[2*AW +: AW]   = 5'd7;
    wb_data_i[2*DW +: DW] = 32'h0000_0077;
    @(negedge clk_i);
    chk("same_ready", 64'(wb_ready_o), 64'b100);
    chk("same_stall", 64'(issue_stall_o), 64'd0);
    push(1'b1, 5'd7, 32'h0000_0077, 1'b1);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    wb_valid_i    = '0;
    pop_chk("same_wr");
    chk("same_busy", 64'(busy_o), 64'((32'h1 << 9) | (32'h1 << 7)));

    // Flush clears every busy bit
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    @(posedge clk_i); #1;
    issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    chk("flush_pre_busy", 64'(busy_o), 64'h288);
    chk("flush_pre_stall", 64'(issue_stall_o), 64'd1);
    issue_valid_i = 1'b0;
    flush_i       = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);

    // Round-robin with all three sources continuously valid from reset
    rst_ni     = 1'b0;
    wb_valid_i = 3'b111;
    for (int k = 0; k < NSRC; k++) begin
      wb_rd_i[k*AW +: AW]   = AW'(10 + k);
      wb_data_i[k*DW +: DW] = DW'(32'hA0 + k);
    end
    #1;
    chk("rr_rst_ready", 64'(wb_ready_o), 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 64'(wb_ready_o), 64'(3'b001 << (i % 3)));
      push(1'b1, AW'(10 + i % 3), DW'(32'hA0 + i % 3), 1'b1);
      @(posedge clk_i); #1;
      pop_chk($sformatf("rr_wr%0d", i));
      @(negedge clk_i);
    end

    // Grant, then reset before the next edge: pending write dropped, rr_ptr back to 0
    chk("mid_ready", 64'(wb_ready_o), 64'b001);
    push(1'b1, 5'd10, 32'hA0, 1'b1);
    @(posedge clk_i); #1;
    pop_chk("mid_wr");
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_we", 64'(reg_write_en_o), 64'd0);
    chk("mid_rst_ready", 64'(wb_ready_o), 64'd0);
    chk("mid_rst_ptr", 64'(rd_ptr_o), 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    #1;
    chk("mid_rr_reset", 64'(wb_ready_o), 64'b001);
    wb_valid_i = '0;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
